// File: rtl/gpio_input_sampler_if.sv
// Signal bundle between the GPIO register block (master) and the pad input sampler (slave).
interface gpio_input_sampler_if #(
    parameter int NrGpio     = 62,
    parameter int PrescWidth = 16
);
    // Handshake: irq_clr_valid_i is a one-cycle strobe with no ready. The sampler
    // applies irq_clr_i on every edge where the strobe is high; it never stalls.
    logic [NrGpio-1:0]     pad_in_i;
    logic [PrescWidth-1:0] presc_i;
    logic [NrGpio-1:0]     deb_en_i;
    logic [NrGpio-1:0]     rise_en_i;
    logic [NrGpio-1:0]     fall_en_i;
    logic                  irq_clr_valid_i;
    logic [NrGpio-1:0]     irq_clr_i;
    logic [NrGpio-1:0]     gpio_o;
    logic [NrGpio-1:0]     irq_status_o;
    logic                  irq_o;

    modport master (
        output pad_in_i, presc_i, deb_en_i, rise_en_i, fall_en_i,
               irq_clr_valid_i, irq_clr_i,
        input  gpio_o, irq_status_o, irq_o
    );

    modport slave (
        input  pad_in_i, presc_i, deb_en_i, rise_en_i, fall_en_i,
               irq_clr_valid_i, irq_clr_i,
        output gpio_o, irq_status_o, irq_o
    );
endinterface

// File: rtl/gpio_input_sampler.sv
// Pad-to-core GPIO input path: two-flop synchronizer, tick-based debounce filter,
// sticky edge interrupt status and a single level interrupt.
module gpio_input_sampler #(
    parameter int NrGpio      = 62,
    parameter int PrescWidth  = 16,
    parameter int DebounceLen = 3
) (
    input logic                 clk_i,
    input logic                 rst_i,
    gpio_input_sampler_if.slave bus
);
    logic [NrGpio-1:0]                  sync1;
    logic [NrGpio-1:0]                  sync2;
    logic [PrescWidth-1:0]              cnt;
    logic [PrescWidth-1:0]              cnt_d;
    logic                               tick;
    logic [NrGpio-1:0][DebounceLen-1:0] shr;
    logic [NrGpio-1:0][DebounceLen-1:0] shr_d;
    logic [NrGpio-1:0]                  gpio_q;
    logic [NrGpio-1:0]                  gpio_d;
    logic [NrGpio-1:0]                  status_q;
    logic [NrGpio-1:0]                  status_d;
    logic [NrGpio-1:0]                  clr_mask;
    logic [NrGpio-1:0]                  rise;
    logic [NrGpio-1:0]                  fall;
    logic [NrGpio-1:0]                  set_mask;
    logic                               irq_q;

    // A compare rather than an equality makes a lowered presc_i tick at once
    // instead of letting the counter run all the way round.
    always_comb begin
        tick  = (cnt >= bus.presc_i);
        cnt_d = tick ? '0 : cnt + PrescWidth'(1);
    end

    // History shifts on every tick whatever deb_en_i says, so enabling the
    // filter later starts from real samples.
    always_comb begin
        shr_d  = shr;
        gpio_d = gpio_q;
        for (int n = 0; n < NrGpio; n++) begin
            if (tick) begin
                shr_d[n] = {shr[n][DebounceLen-2:0], sync2[n]};
            end
            if (!bus.deb_en_i[n]) begin
                gpio_d[n] = sync2[n];
            end else if (tick && ((&shr_d[n]) || !(|shr_d[n]))) begin
                gpio_d[n] = shr_d[n][0];
            end
        end
    end

    // New edges win over a same-cycle clear.
    always_comb begin
        clr_mask = bus.irq_clr_valid_i ? bus.irq_clr_i : '0;
        rise     = gpio_d & ~gpio_q;
        fall     = ~gpio_d & gpio_q;
        set_mask = (rise & bus.rise_en_i) | (fall & bus.fall_en_i);
        status_d = (status_q & ~clr_mask) | set_mask;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1    <= '0;
            sync2    <= '0;
            cnt      <= '0;
            shr      <= '0;
            gpio_q   <= '0;
            status_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            sync1    <= bus.pad_in_i;
            sync2    <= sync1;
            cnt      <= cnt_d;
            shr      <= shr_d;
            gpio_q   <= gpio_d;
            status_q <= status_d;
            irq_q    <= |status_q;
        end
    end

    assign bus.gpio_o       = gpio_q;
    assign bus.irq_status_o = status_q;
    assign bus.irq_o        = irq_q;
endmodule

// File: tb/tb_gpio_input_sampler.sv
// Bench for gpio_input_sampler: vector table, hand-written corner sequences and
// randomized traffic checked against a run-length reference model.
module tb_gpio_input_sampler;
    localparam int NrGpio      = 62;
    localparam int PrescWidth  = 16;
    localparam int DebounceLen = 3;
    localparam int W           = 2 * NrGpio + 1;
    localparam logic [NrGpio-1:0] P0  = 62'h1;
    localparam logic [NrGpio-1:0] P5  = 62'h20;
    localparam logic [NrGpio-1:0] P61 = {1'b1, 61'h0};
    localparam logic [NrGpio-1:0] ALL = 62'h3FFF_FFFF_FFFF_FFFF;

    typedef struct {
        logic [NrGpio-1:0] pad;
        logic              clr_valid;
        logic [NrGpio-1:0] clr;
        logic [NrGpio-1:0] exp_gpio;
        logic [NrGpio-1:0] exp_status;
        logic              exp_irq;
    } vec_t;

    logic clk;
    logic rst;
    int   pass_cnt  = 0;
    int   check_cnt = 0;

    vec_t           vecs[15];
    logic [W-1:0]   exp_q[$];
    logic [NrGpio-1:0] pad_hist[$];
    bit             m_run_val[NrGpio];
    int             m_run_len[NrGpio];
    logic [NrGpio-1:0] m_gpio;
    logic [NrGpio-1:0] m_status;
    logic           m_irq;
    int             m_edge;

    gpio_input_sampler_if #(.NrGpio(NrGpio), .PrescWidth(PrescWidth)) bus ();

    gpio_input_sampler #(
        .NrGpio(NrGpio), .PrescWidth(PrescWidth), .DebounceLen(DebounceLen)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus(bus.slave)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(string name, logic [127:0] act, logic [127:0] exp);
        check_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic check_range(string name, int act, int lo, int hi);
        check_cnt++;
        if (act >= lo && act <= hi) pass_cnt++;
        else $display("FAIL %s: got %0d required %0d..%0d", name, act, lo, hi);
    endtask

    function automatic logic [NrGpio-1:0] rand62();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[NrGpio-1:0];
    endfunction

    task automatic step_cycles(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Ends on a falling edge with reset released and the model at its reset state.
    task automatic do_reset();
        @(negedge clk);
        rst                 = 1'b1;
        bus.pad_in_i        = '0;
        bus.presc_i         = '0;
        bus.deb_en_i        = '0;
        bus.rise_en_i       = '0;
        bus.fall_en_i       = '0;
        bus.irq_clr_valid_i = 1'b0;
        bus.irq_clr_i       = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        pad_hist.delete();
        pad_hist.push_back('0);
        pad_hist.push_back('0);
        for (int n = 0; n < NrGpio; n++) begin
            m_run_val[n] = 1'b0;
            m_run_len[n] = DebounceLen;
        end
        m_gpio   = '0;
        m_status = '0;
        m_irq    = 1'b0;
        m_edge   = 0;
        exp_q.delete();
    endtask

    // Reference model: pads reach the filter two edges late; ticks fall on every
    // (presc+1)-th edge since reset; a level is accepted once its run of equal
    // tick samples reaches DebounceLen.
    task automatic model_step();
        logic [NrGpio-1:0] seen;
        logic [NrGpio-1:0] nxt;
        logic [NrGpio-1:0] setv;
        logic [NrGpio-1:0] clrv;
        int  p;
        bit  tk;
        seen = pad_hist.pop_front();
        pad_hist.push_back(bus.pad_in_i);
        p  = int'(bus.presc_i);
        tk = ((m_edge % (p + 1)) == p);
        m_edge++;
        nxt = m_gpio;
        for (int n = 0; n < NrGpio; n++) begin
            if (tk) begin
                if (seen[n] == m_run_val[n]) m_run_len[n]++;
                else begin
                    m_run_val[n] = seen[n];
                    m_run_len[n] = 1;
                end
            end
            if (!bus.deb_en_i[n]) nxt[n] = seen[n];
            else if (tk && m_run_len[n] >= DebounceLen) nxt[n] = m_run_val[n];
        end
        m_irq    = |m_status;
        setv     = (nxt & ~m_gpio & bus.rise_en_i) | (~nxt & m_gpio & bus.fall_en_i);
        clrv     = bus.irq_clr_valid_i ? bus.irq_clr_i : '0;
        m_status = (m_status & ~clrv) | setv;
        m_gpio   = nxt;
        exp_q.push_back({m_irq, m_status, m_gpio});
    endtask

    initial begin
        int presc_list[3];
        int lat;
        bit bad;
        logic [W-1:0] exp;

        rst = 1'b1;
        // Row r: gpio_o after edge r follows the pad of row r-2.
        vecs[0]  = '{62'h0, 1'b0, 62'h0, 62'h0, 62'h0, 1'b0};
        vecs[1]  = '{P5,    1'b0, 62'h0, 62'h0, 62'h0, 1'b0};
        vecs[2]  = '{P5,    1'b0, 62'h0, 62'h0, 62'h0, 1'b0};
        vecs[3]  = '{P5,    1'b0, 62'h0, P5,    P5,    1'b0};
        vecs[4]  = '{62'h0, 1'b0, 62'h0, P5,    P5,    1'b1};
        vecs[5]  = '{62'h0, 1'b0, 62'h0, P5,    P5,    1'b1};
        vecs[6]  = '{62'h0, 1'b0, 62'h0, 62'h0, P5,    1'b1};
        vecs[7]  = '{62'h0, 1'b0, P5,    62'h0, P5,    1'b1};
        vecs[8]  = '{62'h0, 1'b1, P5,    62'h0, 62'h0, 1'b1};
        vecs[9]  = '{62'h0, 1'b0, 62'h0, 62'h0, 62'h0, 1'b0};
        vecs[10] = '{P0,    1'b0, 62'h0, 62'h0, 62'h0, 1'b0};
        vecs[11] = '{P0,    1'b0, 62'h0, 62'h0, 62'h0, 1'b0};
        vecs[12] = '{P0,    1'b1, P0,    P0,    P0,    1'b0};
        vecs[13] = '{P0,    1'b1, P0,    P0,    62'h0, 1'b1};
        vecs[14] = '{P0,    1'b0, 62'h0, P0,    62'h0, 1'b0};

        // Reset state, then the vector table (debounce off, rise on pins 5 and 0)
        do_reset();
        check("reset_state", {bus.irq_o, bus.irq_status_o, bus.gpio_o}, '0);
        bus.rise_en_i = P5 | P0;
        for (int r = 0; r < 15; r++) begin
            bus.pad_in_i        = vecs[r].pad;
            bus.irq_clr_valid_i = vecs[r].clr_valid;
            bus.irq_clr_i       = vecs[r].clr;
            @(posedge clk);
            #1;
            check($sformatf("tbl_gpio[%0d]", r), bus.gpio_o, vecs[r].exp_gpio);
            check($sformatf("tbl_status[%0d]", r), bus.irq_status_o, vecs[r].exp_status);
            check($sformatf("tbl_irq[%0d]", r), bus.irq_o, vecs[r].exp_irq);
            @(negedge clk);
        end

        // Debounce on pin 61, presc 3: glitch rejection then a stable high
        do_reset();
        bus.presc_i   = 16'd3;
        bus.deb_en_i  = P61;
        bus.rise_en_i = P61;
        bus.fall_en_i = P61;
        bus.pad_in_i  = P61;
        step_cycles(8);
        bus.pad_in_i = '0;
        bad = 1'b0;
        for (int c = 0; c < 20; c++) begin
            step_cycles(1);
            if (bus.gpio_o[61] || (|bus.irq_status_o)) bad = 1'b1;
        end
        check("glitch_reject", bad, 1'b0);
        bus.pad_in_i = P61;
        lat = 99;
        for (int i = 1; i <= 17; i++) begin
            step_cycles(1);
            if (bus.gpio_o[61]) begin
                lat = i;
                break;
            end
        end
        check_range("deb_latency", lat, 11, 17);
        check("deb_status", bus.irq_status_o, P61);

        // Prescaler: lower presc_i below the running count
        do_reset();
        bus.presc_i = 16'hFFFF;
        lat = 0;
        for (int i = 0; i < 2000; i++) begin
            step_cycles(1);
            if (dut.cnt == 16'd1000) begin
                lat = 1;
                break;
            end
        end
        check("presc_reach_1000", lat, 1);
        bus.presc_i = 16'd2;
        #1;
        check("presc_forced_tick", dut.tick, 1'b1);
        for (int i = 0; i < 9; i++) begin
            step_cycles(1);
            check($sformatf("presc_spacing[%0d]", i), dut.tick, (i % 3 == 2));
        end

        // All pins: rise, mask clear, fall, then asynchronous reset and idle
        do_reset();
        bus.rise_en_i = ALL;
        bus.fall_en_i = ALL;
        bus.pad_in_i  = ALL;
        step_cycles(2);
        check("all_before", bus.irq_status_o, '0);
        step_cycles(1);
        check("all_rise_status", bus.irq_status_o, ALL);
        bus.irq_clr_valid_i = 1'b1;
        bus.irq_clr_i       = 62'h3FFF_FFFF_FFFF_FFFF;
        step_cycles(1);
        bus.irq_clr_valid_i = 1'b0;
        check("all_clr_status", bus.irq_status_o, '0);
        check("all_clr_irq_hold", bus.irq_o, 1'b1);
        step_cycles(1);
        check("all_clr_irq_drop", bus.irq_o, 1'b0);
        bus.pad_in_i = '0;
        step_cycles(3);
        check("all_fall_status", bus.irq_status_o, ALL);
        step_cycles(1);
        #2;
        rst = 1'b1;
        #1;
        check("async_reset", {bus.irq_o, bus.irq_status_o, bus.gpio_o}, '0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 100; c++) begin
            step_cycles(1);
            check("idle", {bus.irq_o, bus.irq_status_o, bus.gpio_o}, '0);
        end

        // Randomized traffic against the reference model
        presc_list[0] = 0;
        presc_list[1] = 1;
        presc_list[2] = 3;
        for (int ph = 0; ph < 3; ph++) begin
            do_reset();
            bus.presc_i   = PrescWidth'(presc_list[ph]);
            bus.deb_en_i  = rand62();
            bus.rise_en_i = rand62();
            bus.fall_en_i = rand62();
            for (int c = 0; c < 300; c++) begin
                if (c % 100 == 50) bus.deb_en_i = rand62();
                for (int n = 0; n < NrGpio; n++) begin
                    if ($urandom_range(0, 6 * presc_list[ph] + 5) == 0)
                        bus.pad_in_i[n] = ~bus.pad_in_i[n];
                end
                bus.irq_clr_valid_i = ($urandom_range(0, 3) == 0);
                bus.irq_clr_i       = rand62();
                model_step();
                @(posedge clk);
                #1;
                exp = exp_q.pop_front();
                check($sformatf("rand_p%0d[%0d]", presc_list[ph], c),
                      {bus.irq_o, bus.irq_status_o, bus.gpio_o}, exp);
                @(negedge clk);
            end
        end

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end
endmodule

// File: doc/gpio_input_sampler.md
# gpio_input_sampler

Pad-to-core input path for the GPIO subsystem. Per pin, it takes the raw pad input levels (`pad_to_gpio_t` bits `gpioN_i`) and:
- synchronizes them into `clk_i`;
- optionally debounces them on a programmable sample tick;
- presents filtered levels to the GPIO register file;
- latches enabled rise/fall edges into a sticky interrupt status vector that drives a single level interrupt.

It is the receive counterpart of the `gpio_to_pad_t` drive path and sits between the pad frame and the GPIO APB register block.

## Interface
Parameters:
- `NrGpio`, 62, number of pins; bit N corresponds to `gpioN_i`.
- `PrescWidth`, 16, width of the sample-tick prescaler.
- `DebounceLen`, 3, consecutive equal samples required to accept a level change; legal range 2..8.

Ports:
- `clk_i`  in  1  system clock; one clock domain.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `pad_in_i`  in  NrGpio  raw pad levels; asynchronous to `clk_i`.
- `presc_i`  in  PrescWidth  sample tick period minus one; quasi-static.
- `deb_en_i`  in  NrGpio  per-pin debounce enable.
- `rise_en_i`  in  NrGpio  per-pin rising-edge interrupt enable.
- `fall_en_i`  in  NrGpio  per-pin falling-edge interrupt enable.
- `irq_clr_valid_i`  in  1  strobe; apply `irq_clr_i` this cycle.
- `irq_clr_i`  in  NrGpio  write-1-to-clear mask for status bits.
- `gpio_o`  out  NrGpio  filtered input level, registered.
- `irq_status_o`  out  NrGpio  sticky edge status, registered.
- `irq_o`  out  1  registered OR of `irq_status_o`.

## Operation
- **Synchronizer:** two-flop chain per pin, `sync1` then `sync2`, both reset to 0. No logic between the stages.
- **Prescaler:**
  - Counter `cnt` counts up every cycle.
  - When `cnt >= presc_i`, `tick` is asserted for that cycle and `cnt` returns to 0.
  - `presc_i = 0` gives a tick every cycle.
  - Lowering `presc_i` below the current `cnt` forces a tick on the next cycle; the counter never runs to wrap.
- **Sample shift register:** `shr[N]` is DebounceLen bits per pin, reset to 0.
  - On each tick: `shr_next = {shr[L-2:0], sync2}`.
  - `shr` updates on ticks regardless of `deb_en_i`, so toggling the enable never sees stale history.
- **Filtered level `gpio_o[N]`:**
  - `deb_en_i[N] = 0`: `gpio_o[N]` loads `sync2[N]` every cycle.
  - `deb_en_i[N] = 1`: on a tick cycle, if every bit of `shr_next[N]` equals v and v != `gpio_o[N]`, `gpio_o[N]` loads v on that edge. Otherwise it holds.
  - Clearing `deb_en_i[N]` makes `gpio_o` follow `sync2` the next cycle. The resulting change is a real edge event.
- **Edge events:**
  - `rise[N]` = `gpio_o` goes 0→1 on this edge; `fall[N]` = `gpio_o` goes 1→0 on this edge. Both are computed from the next value versus the current value.
  - `set[N] = (rise & rise_en_i) | (fall & fall_en_i)`.
- **Status update:** `status_next = (status & ~(irq_clr_valid_i ? irq_clr_i : 0)) | set`.
  - Set has priority over a same-cycle clear.
  - A clear with `irq_clr_valid_i = 0` is ignored.
  - Disabling an enable does not clear already-set status bits.
- **Interrupt:** `irq_o` is the OR of `irq_status_o`, registered.
- **Reset state:** all outputs and all internal state reset to 0.
  - `gpio_o = 0`, `irq_status_o = 0`, `irq_o = 0`, `cnt = 0`, `shr = 0`, sync flops 0.
  - A pad held high through reset therefore produces a rising edge after reset release; firmware enables interrupts only after gpio_o settles.
- **Reset mid-operation:** asynchronous. All state clears immediately; no partial status survives.

## Timing
Edge 1 is the first `clk_i` edge after the pad change, assuming setup is met.
- **Debounce off:**
  - `sync1` at edge 1, `sync2` at edge 2.
  - `gpio_o` and `irq_status_o` change at edge 3.
  - `irq_o` rises at edge 4.
- **Debounce on, `presc_i = 0`, L = 3:**
  - `shr` captures the new level at edges 3, 4, 5.
  - `gpio_o` and `irq_status_o` change at edge 5.
  - `irq_o` rises at edge 6.
- **General debounce latency:** 2 sync cycles plus L ticks, plus 0..`presc_i` cycles of tick phase.
- **Clear:** `irq_clr_valid_i` at edge k clears status at edge k. `irq_o` falls at edge k+1 if no other bits remain set.
- **Glitch rejection:** a pulse shorter than L consecutive ticks, measured at `sync2`, never changes `gpio_o` when debounce is on.
- **Constraints:**
  - The `sync1` D input is the only asynchronous crossing.
  - `presc_i` and the enables are assumed stable; any change takes effect the next cycle.

## Test plan
- **Reset and idle:** assert `rst_i` mid-run with state set. All outputs go 0 immediately, before any clock edge. After release, with pad = 0, outputs stay 0 for 100 cycles.
- **Debounce off, rise only on pin 5:** `rise_en[5] = 1`, pad5 0→1→0. Required response:
  - `gpio_o[5]` rises at edge 3.
  - `irq_status_o[5]` sets at edge 3.
  - `irq_o` rises at edge 4.
  - The falling edge sets no status.
- **Debounce on, `presc_i = 3`, L = 3, pin 61:**
  - A 2-tick (8-cycle) high pulse leaves `gpio_o[61]` at 0 and sets no status.
  - A 12-cycle stable high sets `gpio_o[61]` within 2 + 12 + 3 cycles.
- **Set/clear collision:** pin 0 edge sets status on the same cycle as `irq_clr_valid_i = 1` with `irq_clr_i[0] = 1`. `irq_status_o[0]` stays 1 and `irq_o` stays 1.
- **Prescaler boundary:** run with `presc_i = 0xFFFF`. Drop `presc_i` to 2 when `cnt = 1000`. A tick occurs on the next cycle, and ticks are then spaced every 3 cycles.
- **All pins simultaneously:** all enables set, all pads toggle. `irq_status_o` becomes all-ones (62 bits). Clearing with mask `0x3FFF_FFFF_FFFF_FFFF` drops `irq_o` one cycle later.
